// File: rtl/riscv_mmio_uart_tx_pkg.sv
// rtl/riscv_mmio_uart_tx_pkg.sv - shared constants for the MMIO UART transmitter
package riscv_mmio_uart_tx_pkg;

  // Store width presented by the core's load/store port
  typedef enum logic [1:0] {
    MASK_BYTE = 2'd0,
    MASK_HALF = 2'd1,
    MASK_WORD = 2'd2
  } MASK_SEL;

  // Active level of the store strobe
  localparam logic MEM_WEN = 1'b1;

  // Transmit FSM states
  localparam logic [1:0] UART_IDLE  = 2'd0;
  localparam logic [1:0] UART_START = 2'd1;
  localparam logic [1:0] UART_DATA  = 2'd2;
  localparam logic [1:0] UART_STOP  = 2'd3;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

  // Packs the STATUS register image
  function automatic logic [7:0] uart_status(input logic busy, input logic full,
                                             input logic empty, input logic overflow,
                                             input logic [3:0] count);
    return {count, overflow, empty, full, busy};
  endfunction

endpackage

// File: rtl/riscv_mmio_uart_tx_if.sv
// rtl/riscv_mmio_uart_tx_if.sv - core data-bus port seen by the UART responder
interface riscv_mmio_uart_tx_if;
  import riscv_mmio_uart_tx_pkg::*;

  logic [31:0] addr;
  logic        write_en;
  logic [31:0] wdata;
  MASK_SEL     mask_sel;
  logic        hit;
  logic [31:0] dout;

  modport master (output addr, write_en, wdata, mask_sel, input hit, dout);
  modport slave  (input addr, write_en, wdata, mask_sel, output hit, dout);
endinterface

// File: rtl/riscv_sync_fifo.sv
// rtl/riscv_sync_fifo.sv - synchronous FIFO with MSB-compare wrap detection
module riscv_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_ok   = pop && !empty;
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_mmio_uart_tx.sv
// rtl/riscv_mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module riscv_mmio_uart_tx
  import riscv_mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  x_reset,
  riscv_mmio_uart_tx_if.slave   bus,
  output logic                  tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]  reg_sel;
  logic        wr;
  logic        push;
  logic        pop;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [31:0] count_w;
  logic [3:0]  count_sat;
  logic        overflow;
  logic [15:0] divisor;
  logic [15:0] reload;
  logic [1:0]  state;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        busy;
  logic        unused_bits;

  assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = bus.addr[3:2];
  assign wr          = bus.hit && (bus.write_en == MEM_WEN);
  assign push        = wr && (reg_sel == UART_REG_TXDATA);
  assign busy        = (state != UART_IDLE);
  assign count_w     = 32'(fifo_count);
  assign count_sat   = (count_w > 32'd15) ? 4'hF : count_w[3:0];
  // A divisor of 0 behaves as 1 cycle per bit
  assign reload      = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  // Pop on leaving IDLE or at the end of a stop bit, so frames run back-to-back
  assign pop         = !fifo_empty && ((state == UART_IDLE) ||
                                       (state == UART_STOP && baud_cnt == 16'd0));
  assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

  riscv_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (x_reset),
    .push      (push),
    .push_data (bus.wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Zero-latency register readback, 0 outside the window
  always_comb begin
    bus.dout = 32'd0;
    if (bus.hit) begin
      case (reg_sel)
        UART_REG_STATUS:  bus.dout = {24'd0, uart_status(busy, fifo_full, fifo_empty,
                                                          overflow, count_sat)};
        UART_REG_DIVISOR: bus.dout = {16'd0, divisor};
        default:          bus.dout = 32'd0;
      endcase
    end
  end

  // Sticky overflow flag and the baud divisor register
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      overflow <= 1'b0;
      divisor  <= CLK_DIV;
    end else begin
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (wr && reg_sel == UART_REG_STATUS && bus.wdata[3])
        overflow <= 1'b0;
      if (wr && reg_sel == UART_REG_DIVISOR && bus.mask_sel == MASK_WORD)
        divisor <= bus.wdata[15:0];
    end
  end

  // Frame serialiser; each bit length is latched into baud_cnt at its start
  always_ff @(posedge clk or posedge x_reset) begin
    if (x_reset) begin
      state    <= UART_IDLE;
      tx       <= 1'b1;
      shift    <= 8'd0;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
    end else begin
      case (state)
        UART_IDLE: begin
          if (pop) begin
            state    <= UART_START;
            shift    <= fifo_data;
            tx       <= 1'b0;
            baud_cnt <= reload;
          end
        end
        UART_START: begin
          if (baud_cnt == 16'd0) begin
            state    <= UART_DATA;
            tx       <= shift[0];
            bit_cnt  <= 3'd0;
            baud_cnt <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        UART_DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= reload;
            if (bit_cnt == 3'd7) begin
              state <= UART_STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        UART_STOP: begin
          if (baud_cnt == 16'd0) begin
            if (pop) begin
              state    <= UART_START;
              shift    <= fifo_data;
              tx       <= 1'b0;
              baud_cnt <= reload;
            end else begin
              state <= UART_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule
